// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding / load-use hazard unit.
// The pipeline (master) drives ID/EX/MEM stage info and consumes the
// hold, bubble and forward-select controls.
interface fwd_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [REG_AW-1:0]           idex_rd;
  logic [REG_AW-1:0]           exmem_rd;
  logic                        idex_regwrite;
  logic                        exmem_regwrite;
  logic                        idex_memread;
  logic                        mem_busy;
  logic [NUM_SRC*2-1:0]        fwd_sel;
  logic                        pc_hold;
  logic                        ifid_hold;
  logic                        idex_bubble;
  logic                        lu_busy;
  logic [15:0]                 stall_cycles;

  modport master (
    output id_valid, id_src, id_src_used, idex_rd, exmem_rd,
           idex_regwrite, exmem_regwrite, idex_memread, mem_busy,
    input  fwd_sel, pc_hold, ifid_hold, idex_bubble, lu_busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_src, id_src_used, idex_rd, exmem_rd,
           idex_regwrite, exmem_regwrite, idex_memread, mem_busy,
    output fwd_sel, pc_hold, ifid_hold, idex_bubble, lu_busy, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Forward selects are resolved in ID
// and registered into EX; a small FSM inserts LOAD_STALL bubbles when an
// instruction in ID consumes a load still in EX. mem_busy freezes all state.
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1
) (
  input  logic               clk,
  input  logic               reset,
  fwd_hazard_unit_if.slave   bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LU_STALL = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [2:0]            r_rem;
  logic [2:0]            w_rem_next;
  logic [NUM_SRC*2-1:0]  r_fwd_sel;
  logic [15:0]           r_stall_cycles;

  logic [NUM_SRC-1:0]    w_ex_match;
  logic [NUM_SRC-1:0]    w_mem_match;
  logic [NUM_SRC*2-1:0]  w_fwd_calc;
  logic                  w_hazard;
  logic                  w_bubble;
  logic                  w_hold;

  // Per-operand producer matching; the EX-stage producer is the most recent
  // one, so it wins over the MEM-stage producer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] w_src;
      logic              w_live;
      assign w_src  = bus.id_src[gi*REG_AW +: REG_AW];
      assign w_live = bus.id_valid && bus.id_src_used[gi] && (w_src != '0);
      assign w_ex_match[gi]  = w_live && bus.idex_regwrite  && (bus.idex_rd  == w_src);
      assign w_mem_match[gi] = w_live && bus.exmem_regwrite && (bus.exmem_rd == w_src);
      assign w_fwd_calc[gi*2 +: 2] = w_ex_match[gi]  ? 2'b10 :
                                     w_mem_match[gi] ? 2'b01 : 2'b00;
    end
  endgenerate

  // A load in EX feeding ID cannot be forwarded in time; a frozen pipeline
  // never raises a hazard.
  assign w_hazard = (|w_ex_match) && bus.idex_memread && !bus.mem_busy;

  // State register: FSM and remaining-bubble counter hold while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rem   <= 3'd0;
    end else if (!bus.mem_busy) begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
    end
  end

  // Next-state logic: the first bubble is issued from IDLE, the rest from LU_STALL.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    case (r_state)
      ST_IDLE: begin
        if (w_hazard && (LOAD_STALL > 1)) begin
          w_state_next = ST_LU_STALL;
          w_rem_next   = 3'(LOAD_STALL - 1);
        end
      end
      ST_LU_STALL: begin
        w_rem_next = r_rem - 3'd1;
        if (r_rem == 3'd1) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_rem_next   = 3'd0;
      end
    endcase
  end

  // Output logic: freeze holds the front end without bubbling; stalls bubble and hold.
  always_comb begin
    w_bubble = 1'b0;
    w_hold   = 1'b0;
    if (bus.mem_busy) begin
      w_hold = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_bubble = w_hazard;
          w_hold   = w_hazard;
        end
        ST_LU_STALL: begin
          w_bubble = 1'b1;
          w_hold   = 1'b1;
        end
        default: begin
          w_bubble = 1'b0;
          w_hold   = 1'b0;
        end
      endcase
    end
  end

  // Forward selects are registered into EX; a bubble entering EX needs no forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_sel <= '0;
    end else if (!bus.mem_busy) begin
      r_fwd_sel <= w_bubble ? '0 : w_fwd_calc;
    end
  end

  // Saturating count of bubble cycles; bubble is never raised while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
    end else if (w_bubble && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign bus.fwd_sel      = r_fwd_sel;
  assign bus.pc_hold      = w_hold;
  assign bus.ifid_hold    = w_hold;
  assign bus.idex_bubble  = w_bubble;
  assign bus.lu_busy      = (r_state == ST_LU_STALL);
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench: two instances (LOAD_STALL=1 and 3) driven with identical
// stimulus, each compared every cycle against a bubble-count reference model.
module tb_fwd_hazard_unit;
  localparam int AW = 5;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          id_valid;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0] id_src_used;
  logic [AW-1:0] idex_rd, exmem_rd;
  logic          idex_regwrite, exmem_regwrite, idex_memread, mem_busy;

  fwd_hazard_unit_if #(.REG_AW(AW), .NUM_SRC(NS)) if1 ();
  fwd_hazard_unit_if #(.REG_AW(AW), .NUM_SRC(NS)) if3 ();

  assign if1.id_valid = id_valid;        assign if3.id_valid = id_valid;
  assign if1.id_src = id_src;            assign if3.id_src = id_src;
  assign if1.id_src_used = id_src_used;  assign if3.id_src_used = id_src_used;
  assign if1.idex_rd = idex_rd;          assign if3.idex_rd = idex_rd;
  assign if1.exmem_rd = exmem_rd;        assign if3.exmem_rd = exmem_rd;
  assign if1.idex_regwrite = idex_regwrite;   assign if3.idex_regwrite = idex_regwrite;
  assign if1.exmem_regwrite = exmem_regwrite; assign if3.exmem_regwrite = exmem_regwrite;
  assign if1.idex_memread = idex_memread;     assign if3.idex_memread = idex_memread;
  assign if1.mem_busy = mem_busy;        assign if3.mem_busy = mem_busy;

  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_STALL(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1));
  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_STALL(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(if3));

  int n_cmp = 0;
  int n_mism = 0;

  // Reference model state per instance: bubbles still owed after this cycle.
  int          ls_tab [2] = '{1, 3};
  int          m_pend [2];
  logic [3:0]  m_fwd  [2];
  logic [15:0] m_cnt  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mism++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_fwd();
    logic [3:0] r = 4'b0;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] s = id_src[i*AW +: AW];
      bit live = id_valid && id_src_used[i] && (s != 0);
      if (live && idex_regwrite && idex_rd == s)        r[i*2 +: 2] = 2'b10;
      else if (live && exmem_regwrite && exmem_rd == s) r[i*2 +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit ref_ex_hit();
    bit h = 0;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] s = id_src[i*AW +: AW];
      if (id_valid && id_src_used[i] && s != 0 && idex_regwrite && idex_rd == s) h = 1;
    end
    return h;
  endfunction

  // One clock: compare at the falling edge, advance the model across the rising edge.
  task automatic cycle();
    bit         hz, bub;
    logic [3:0] calc;
    logic [3:0] o_fwd;
    logic       o_ph, o_ih, o_bub, o_lu;
    logic [15:0] o_cnt;
    int         n_pend [2];
    logic [3:0] n_fwd [2];
    logic [15:0] n_cnt [2];
    @(negedge clk);
    hz   = !mem_busy && idex_memread && ref_ex_hit();
    calc = ref_fwd();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o_fwd = if1.fwd_sel; o_ph = if1.pc_hold; o_ih = if1.ifid_hold;
        o_bub = if1.idex_bubble; o_lu = if1.lu_busy; o_cnt = if1.stall_cycles;
      end else begin
        o_fwd = if3.fwd_sel; o_ph = if3.pc_hold; o_ih = if3.ifid_hold;
        o_bub = if3.idex_bubble; o_lu = if3.lu_busy; o_cnt = if3.stall_cycles;
      end
      bub = !mem_busy && (m_pend[k] > 0 || hz);
      check_eq($sformatf("L%0d bubble", ls_tab[k]), 32'(o_bub), 32'(bub));
      check_eq($sformatf("L%0d pc_hold", ls_tab[k]), 32'(o_ph), 32'(mem_busy || bub));
      check_eq($sformatf("L%0d ifid_hold", ls_tab[k]), 32'(o_ih), 32'(mem_busy || bub));
      check_eq($sformatf("L%0d lu_busy", ls_tab[k]), 32'(o_lu), 32'(m_pend[k] > 0));
      check_eq($sformatf("L%0d fwd_sel", ls_tab[k]), 32'(o_fwd), 32'(m_fwd[k]));
      check_eq($sformatf("L%0d stall_cycles", ls_tab[k]), 32'(o_cnt), 32'(m_cnt[k]));
      n_pend[k] = m_pend[k]; n_fwd[k] = m_fwd[k]; n_cnt[k] = m_cnt[k];
      if (reset) begin
        n_pend[k] = 0; n_fwd[k] = 4'b0; n_cnt[k] = 16'd0;
      end else if (!mem_busy) begin
        if (m_pend[k] > 0) n_pend[k] = m_pend[k] - 1;
        else if (hz)       n_pend[k] = ls_tab[k] - 1;
        n_fwd[k] = bub ? 4'b0 : calc;
        if (bub && m_cnt[k] != 16'hFFFF) n_cnt[k] = m_cnt[k] + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = n_pend[k]; m_fwd[k] = n_fwd[k]; m_cnt[k] = n_cnt[k];
    end
  endtask

  task automatic drive(input bit v, input int s0, input int s1, input logic [1:0] used,
                       input int erd, input bit erw, input bit mr,
                       input int mrd, input bit mrw, input bit busy);
    id_valid = v; id_src = {AW'(s1), AW'(s0)}; id_src_used = used;
    idex_rd = AW'(erd); idex_regwrite = erw; idex_memread = mr;
    exmem_rd = AW'(mrd); exmem_regwrite = mrw; mem_busy = busy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_fwd[k] = 4'b0; m_cnt[k] = 16'd0;
    end
    reset = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;
    check_eq("reset fwd_sel", 32'(if3.fwd_sel), 32'h0);
    check_eq("reset stall_cycles", 32'(if3.stall_cycles), 32'h0);

    // add r3 in EX, sub reads r3 in operand 0
    drive(1, 3, 4, 2'b11, 3, 1, 0, 0, 0, 0);
    cycle();
    check_eq("ex fwd op0", 32'(if1.fwd_sel), 32'h2);

    // r5 written by both EX and MEM: most recent wins
    drive(1, 5, 5, 2'b11, 5, 1, 0, 5, 1, 0);
    cycle();
    check_eq("ex over mem", 32'(if1.fwd_sel), 32'hA);
    drive(1, 0, 0, 2'b11, 0, 1, 0, 0, 1, 0);
    cycle();
    check_eq("r0 no fwd", 32'(if1.fwd_sel), 32'h0);

    // lw r7 in EX, consumer in ID; then load moves to MEM
    do_reset();
    drive(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0);
    cycle();
    check_eq("L3 lu_busy after 1st", 32'(if3.lu_busy), 32'h1);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0);
    repeat (3) cycle();
    check_eq("L3 bubble count", 32'(if3.stall_cycles), 32'd3);
    check_eq("L1 bubble count", 32'(if1.stall_cycles), 32'd1);

    // freeze in the middle of a stall
    do_reset();
    drive(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0);
    cycle();
    drive(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 1);
    repeat (4) cycle();
    check_eq("freeze lu_busy held", 32'(if3.lu_busy), 32'h1);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0);
    repeat (3) cycle();
    check_eq("freeze total bubbles", 32'(if3.stall_cycles), 32'd3);

    // reset during LU_STALL with two bubbles left
    do_reset();
    drive(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    do_reset();
    check_eq("mid-stall reset lu_busy", 32'(if3.lu_busy), 32'h0);
    check_eq("mid-stall reset count", 32'(if3.stall_cycles), 32'h0);

    // saturation of the bubble counter
    force u_dut3.r_stall_cycles = 16'hFFFE;
    m_cnt[1] = 16'hFFFE;
    #1;
    release u_dut3.r_stall_cycles;
    drive(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0);
    cycle();
    drive(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0);
    repeat (3) cycle();
    check_eq("saturated count", 32'(if3.stall_cycles), 32'hFFFF);

    // randomized traffic over a small register window to provoke matches
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1) != 0,
            $urandom_range(0, 4) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end
endmodule
